// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pipe_pkg
// Brief    : Shared constants and helpers for the pipe_ex result collector.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int PIPE_N        = 10;
    localparam int PIPE_LAT      = 3;
    localparam int COLLECT_DEPTH = 4;
    localparam int ACC_W         = 16;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_res_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pipe_res_fifo
// Brief    : Synchronous result FIFO with combinational read port and count.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_res_fifo
    import pipe_pkg::*;
#(
    parameter int N     = PIPE_N,
    parameter int DEPTH = COLLECT_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [N-1:0]              din,
    output logic [N-1:0]              dout,
    output logic [ptr_width(DEPTH):0] count,
    output logic                      full,
    output logic                      empty
);

    localparam int              c_pw      = ptr_width(DEPTH);
    localparam int              c_cw      = c_pw + 1;
    localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
    localparam logic [c_pw-1:0] c_ptr_one = c_pw'(1);

    logic [N-1:0]    r_mem [DEPTH];
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic            w_wr_en;
    logic            w_rd_en;

    assign full    = (r_count == c_depth);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign dout    = r_mem[r_rd_ptr];

    // A write into a full FIFO is only legal when the same edge frees a slot.
    assign w_rd_en = pop && !empty;
    assign w_wr_en = push && (!full || w_rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_wr_en && !w_rd_en) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_rd_en && !w_wr_en) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : pipe_result_collector
// Brief    : Valid tracking, result FIFO, running sum and drop flag for pipe_ex.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_result_collector
    import pipe_pkg::*;
#(
    parameter int N     = PIPE_N,
    parameter int LAT   = PIPE_LAT,
    parameter int DEPTH = COLLECT_DEPTH,
    parameter int ACC_W = pipe_pkg::ACC_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [N-1:0]              f_in,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [N-1:0]              out_data,
    output logic [ptr_width(DEPTH):0] count,
    output logic [ACC_W-1:0]          acc,
    output logic                      overflow
);

    logic [LAT-1:0]   r_vsr;
    logic [ACC_W-1:0] r_acc;
    logic             r_overflow;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_drop;

    // The valid bit travels alongside the operands through pipe_ex.
    generate
        if (LAT == 1) begin : g_vsr_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vsr <= '0;
                end else begin
                    r_vsr <= in_valid;
                end
            end
        end else begin : g_vsr_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vsr <= '0;
                end else begin
                    r_vsr <= {r_vsr[LAT-2:0], in_valid};
                end
            end
        end
    endgenerate

    assign w_push    = r_vsr[LAT-1];
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign w_accept  = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    pipe_res_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_accept),
        .pop   (w_pop),
        .din   (f_in),
        .dout  (out_data),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc <= r_acc + ACC_W'(f_in);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign acc      = r_acc;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pipe_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_result_collector
// Brief    : Scoreboard bench for pipe_result_collector with a queue-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_result_collector;

    localparam int c_n     = 10;
    localparam int c_lat   = 3;
    localparam int c_depth = 4;
    localparam int c_acc_w = 16;
    localparam int c_hist  = 4096;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic [c_n-1:0]     f_in;
    logic               out_ready;
    logic               out_valid;
    logic [c_n-1:0]     out_data;
    logic [2:0]         count;
    logic [c_acc_w-1:0] acc;
    logic               overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Issue history indexed by the edge that captured the operands.
    bit             issued [c_hist];
    logic [c_n-1:0] fv     [c_hist];

    logic [c_n-1:0]     m_q[$];
    logic [c_n-1:0]     exp_q[$];
    logic [c_acc_w-1:0] e_acc;
    bit                 e_ovf;

    logic [c_n-1:0] stream_f [8] = '{10'd75, 10'd66, 10'd112, 10'd62,
                                     10'd0,  10'd66, 10'd49,  10'd116};

    pipe_result_collector #(
        .N     (c_n),
        .LAT   (c_lat),
        .DEPTH (c_depth),
        .ACC_W (c_acc_w)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .f_in      (f_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (count),
        .acc       (acc),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [c_n-1:0] pipe_f(input logic [c_n-1:0] a, b, c, d);
        return ((a + b) + (c - d)) * d;
    endfunction

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        e_acc = '0;
        e_ovf = 1'b0;
        for (int i = 0; i < c_hist; i++) issued[i] = 1'b0;
    endtask

    // What one clock edge does to the stored results, expressed as queue operations.
    task automatic model_edge(input int e);
        bit             push;
        bit             full;
        bit             pop;
        logic [c_n-1:0] f;
        push = 1'b0;
        f    = '0;
        if (e >= c_lat) begin
            push = issued[e-c_lat];
            f    = fv[e-c_lat];
        end
        full = (m_q.size() == c_depth);
        pop  = (m_q.size() != 0) && out_ready;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (!full || pop) begin
                m_q.push_back(f);
                exp_q.push_back(f);
                e_acc = e_acc + c_acc_w'(f);
            end else begin
                e_ovf = 1'b1;
            end
        end
    endtask

    // Drive one cycle: f_in carries F only in the cycle before its capture edge.
    task automatic step(input bit v, input logic [c_n-1:0] f, input bit rdy);
        int e = cyc + 1;
        in_valid  = v;
        out_ready = rdy;
        issued[e] = v;
        fv[e]     = f;
        if (e >= c_lat && issued[e-c_lat]) f_in = fv[e-c_lat];
        else                               f_in = c_n'($urandom);
        @(posedge clk);
        cyc = e;
        if (rst_n) model_edge(e);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, c_n'($urandom), rdy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        idle(2, 1'b0);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("acc", 32'(acc), 32'(e_acc));
        chk("overflow", 32'(overflow), 32'(e_ovf));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got data %0d expected no output (t=%0t)", out_data, $time);
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [c_n-1:0] a, b, c, d;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        f_in      = '0;
        model_reset();

        // Reset then idle
        idle(2, 1'b0);
        rst_n = 1'b1;
        idle(10, 1'b0);
        chk("idle_count", 32'(count), 0);
        chk("idle_acc", 32'(acc), 0);
        chk("idle_ovf", 32'(overflow), 0);

        // Latency alignment
        do_reset();
        step(1'b1, 10'd75, 1'b0);
        idle(2, 1'b0);
        chk("lat_not_early", 32'(out_valid), 0);
        idle(1, 1'b0);
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 75);
        chk("lat_count", 32'(count), 1);
        chk("lat_acc", 32'(acc), 75);
        idle(3, 1'b1);

        // Streaming
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, stream_f[i], 1'b1);
            chk("stream_count_le1", 32'(count <= 1), 1);
        end
        idle(6, 1'b1);
        chk("stream_acc", 32'(acc), 546);
        chk("stream_ovf", 32'(overflow), 0);

        // Full and drop
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, stream_f[i], 1'b0);
        idle(3, 1'b0);
        chk("full_count", 32'(count), 4);
        chk("full_ovf", 32'(overflow), 1);
        chk("full_acc", 32'(acc), 315);
        idle(6, 1'b1);
        chk("drain_ovf_sticky", 32'(overflow), 1);
        chk("drain_count", 32'(count), 0);

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, c_n'($urandom), 1'b0);
        idle(2, 1'b0);
        chk("pp_full", 32'(count), 4);
        idle(1, 1'b1);
        chk("pp_count", 32'(count), 4);
        chk("pp_ovf", 32'(overflow), 0);
        idle(6, 1'b1);

        // Reset mid-stream with two stored and two in flight
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, c_n'($urandom_range(1, 1023)), 1'b0);
        idle(1, 1'b0);
        chk("mid_stored", 32'(count), 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_acc", 32'(acc), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_data", 32'(out_data), 0);
        idle(2, 1'b0);
        rst_n = 1'b1;
        idle(6, 1'b1);
        chk("post_rst_count", 32'(count), 0);
        step(1'b1, 10'd33, 1'b1);
        idle(5, 1'b1);
        chk("post_rst_acc", 32'(acc), 33);

        // Randomised traffic from real operand sets
        do_reset();
        for (int i = 0; i < 800; i++) begin
            a = c_n'($urandom);
            b = c_n'($urandom);
            c = c_n'($urandom);
            d = c_n'($urandom);
            step($urandom_range(0, 99) < 70, pipe_f(a, b, c, d),
                 $urandom_range(0, 99) < ((i < 400) ? 40 : 85));
        end
        idle(10, 1'b1);
        chk("final_sb_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_result_collector.md
Name: pipe_result_collector

Overview:
- Downstream stage of the 3-stage arithmetic pipeline `pipe_ex`, which computes F = ((A+B)+(C-D))*D with N-bit operands and no valid tracking.
- This block supplies the missing valid tracking. It carries a valid bit alongside each operand set for the fixed pipeline latency.
- It captures each F into a small FIFO and presents results on a ready/valid output port.
- It also keeps a running sum and a sticky overflow flag, for the system controller and for debug.

Parameters:
- N, 10, data width of F; must match `pipe_ex`.
- LAT, 3, `pipe_ex` latency in clock edges, counted from operand capture to F being stable.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- ACC_W, 16, width of the running-sum accumulator.

Ports:
- clk, in, 1, system clock; rising edge.
- rst_n, in, 1, reset, asynchronous, active-low.
- in_valid, in, 1, high in the same cycle that a valid A/B/C/D set is presented to `pipe_ex`.
- f_in, in, N, the F output of `pipe_ex`.
- out_ready, in, 1, consumer accepts out_data this cycle.
- out_valid, out, 1, FIFO not empty.
- out_data, out, N, oldest stored result.
- count, out, $clog2(DEPTH)+1, FIFO occupancy (0..DEPTH).
- acc, out, ACC_W, sum of all accepted results.
- overflow, out, 1, sticky: a result was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - valid shift register vsr[LAT-1:0] = 0.
  - Read/write pointers = 0; count = 0; out_valid = 0.
  - out_data = 0; acc = 0; overflow = 0.
  - Reset mid-operation discards all in-flight valid bits and stored results. Nothing is pushed on the first edge after release.
- Valid alignment:
  - Each edge: vsr[0] <= in_valid; vsr[i] <= vsr[i-1].
  - push = vsr[LAT-1], sampled at the edge.
  - Operands captured by `pipe_ex` at edge k make the matching F sampled into the FIFO at edge k+LAT. With LAT=3 that is edge k+3.
  - Back-to-back in_valid gives one push per cycle.
- Pop: pop = out_valid && out_ready.
- FIFO:
  - Write at wr_ptr and read at rd_ptr; pointers wrap modulo DEPTH.
  - out_data shows mem[rd_ptr] combinationally; 0 when empty is not required.
  - There is no bypass: a push into an empty FIFO raises out_valid after that edge, not in the same cycle.
- Full with push and no pop: the result is dropped; overflow <= 1, and stays 1 until reset. count, pointers and acc are unchanged.
- Full with push and pop in the same cycle: both happen; count stays DEPTH; no overflow.
- Empty with pop: impossible by definition, since out_valid = 0.
- Push and pop with 0 < count < DEPTH: count unchanged; both pointers advance.
- acc:
  - acc <= acc + zero-extended f_in on every accepted push; dropped pushes do not add.
  - Wraps modulo 2^ACC_W with no saturation.
- count updates on the edge: +1 for push only, -1 for pop only, 0 for both or neither.
- Everything is single-clock and fully registered, except the out_data read mux and out_valid = (count != 0).

Decomposition:
- Package pipe_pkg holds:
  - Constants PIPE_N=10 and PIPE_LAT=3.
  - Default COLLECT_DEPTH=4 and ACC_W=16.
  - A helper that computes pointer width from depth.
- Sub-module pipe_res_fifo: a synchronous FIFO with parameters N and DEPTH. Its ports are clk, rst_n, push, pop, din, dout, count, full, empty.
- The top level keeps the valid shift register, the drop/overflow logic and acc.

Test Plan:
1. Reset then idle: hold rst_n low for 2 cycles, release, in_valid=0 for 10 cycles -> out_valid=0, count=0, acc=0, overflow=0 throughout.
2. Latency alignment: a single in_valid at edge k with f_in=75 (4Bh) driven stable from edge k+2 -> push at edge k+3; out_valid=1 after k+3 with out_data=75, count=1, acc=75. Garbage on f_in at other edges is never captured.
3. Streaming: 8 back-to-back valid sets giving F = 75, 66, 112, 62, 0, 66, 49, 116 with out_ready=1 -> outputs appear in that order one per cycle; count ≤ 1; acc=546; overflow=0.
4. Full and drop: out_ready=0 with the same 8 results -> the first 4 (75, 66, 112, 62) are stored; count=4; overflow=1 from the 5th push onward; acc=315. Then out_ready=1 -> the 4 drain in order and overflow stays 1.
5. Full with simultaneous push and pop: FIFO full, then one cycle with push=1 and out_ready=1 -> count stays 4; overflow stays 0; the new value is read out after the existing 4.
6. Reset mid-stream: assert rst_n low asynchronously (between edges) with 2 results stored and 2 in flight -> all outputs are 0 immediately. After release, the in-flight results are never pushed and acc restarts from 0.
